// File: rtl/rx_frame_monitor.sv
// Receive-side monitor for the sequenced test-frame format on the Aurora RX stream.
// Checks header sequence, length and payload pattern, and keeps status counters.
module rx_frame_monitor #(
  parameter int MAX_LEN = 256
) (
  input  logic        USER_CLK,
  input  logic        RESET_N,
  input  logic        CHANNEL_UP,
  input  logic        CLEAR_COUNTS,
  input  logic [0:31] AXI4_S_IP_TX_TDATA,
  input  logic [0:3]  AXI4_S_IP_TX_TKEEP,
  input  logic        AXI4_S_IP_TX_TLAST,
  input  logic        AXI4_S_IP_TX_TVALID,
  output logic [0:31] FRAME_COUNT,
  output logic [0:31] WORD_COUNT,
  output logic [0:15] SEQ_ERR_COUNT,
  output logic [0:15] LEN_ERR_COUNT,
  output logic [0:15] DATA_ERR_COUNT,
  output logic [0:7]  ERR_COUNT,
  output logic        ERR_PULSE,
  output logic        IN_SYNC
);

  typedef enum logic [1:0] {HDR, PAY, DISCARD} state_e;

  localparam logic [15:0] MaxLen = 16'(MAX_LEN);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic inc);
    return (inc && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  // Reset asserts asynchronously but releases two edges later, in step with USER_CLK.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge USER_CLK or negedge RESET_N) begin
    if (!RESET_N) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  state_e      state_q, state_d;
  logic [15:0] seq_q, seq_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] exp_seq_q, exp_seq_d;
  logic        in_sync_q, in_sync_d;
  logic        frame_err_q, frame_err_d;
  logic        err_pulse_q, err_pulse_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [15:0] seq_err_cnt_q, seq_err_cnt_d;
  logic [15:0] len_err_cnt_q, len_err_cnt_d;
  logic [15:0] data_err_cnt_q, data_err_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic        accept;
  logic        keep_err;
  logic        last_beat;
  logic [15:0] hdr_seq;
  logic [15:0] hdr_len;
  logic        seq_err, len_err, data_err, any_err;
  logic        done, frame_ok;

  assign accept    = AXI4_S_IP_TX_TVALID && CHANNEL_UP;
  assign keep_err  = accept && (AXI4_S_IP_TX_TKEEP != 4'hF);
  assign hdr_seq   = AXI4_S_IP_TX_TDATA[0:15];
  assign hdr_len   = AXI4_S_IP_TX_TDATA[16:31];
  assign last_beat = (idx_q == len_q - 16'd1);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    seq_d       = seq_q;
    len_d       = len_q;
    idx_d       = idx_q;
    exp_seq_d   = exp_seq_q;
    in_sync_d   = in_sync_q;
    frame_err_d = frame_err_q;
    seq_err     = 1'b0;
    len_err     = keep_err;
    data_err    = 1'b0;
    done        = 1'b0;

    if (!CHANNEL_UP) begin
      // Losing the channel mid-payload truncates the frame; a discard simply ends.
      in_sync_d = 1'b0;
      if (state_q == PAY) len_err = 1'b1;
      state_d = HDR;
    end else if (AXI4_S_IP_TX_TVALID) begin
      case (state_q)
        HDR: begin
          seq_d     = hdr_seq;
          len_d     = hdr_len;
          idx_d     = '0;
          exp_seq_d = hdr_seq + 16'd1;
          in_sync_d = 1'b1;
          seq_err   = in_sync_q && (hdr_seq != exp_seq_q);
          if (hdr_len > MaxLen) begin
            len_err = 1'b1;
            state_d = AXI4_S_IP_TX_TLAST ? HDR : DISCARD;
          end else if (hdr_len == 16'd0) begin
            if (AXI4_S_IP_TX_TLAST) begin
              done = 1'b1;
            end else begin
              len_err = 1'b1;
              state_d = DISCARD;
            end
          end else if (AXI4_S_IP_TX_TLAST) begin
            len_err = 1'b1;
          end else begin
            state_d = PAY;
          end
        end
        PAY: begin
          data_err = (AXI4_S_IP_TX_TDATA != {seq_q, idx_q});
          idx_d    = idx_q + 16'd1;
          if (AXI4_S_IP_TX_TLAST) begin
            state_d = HDR;
            if (last_beat) done = 1'b1;
            else           len_err = 1'b1;
          end else if (last_beat) begin
            len_err = 1'b1;
            state_d = DISCARD;
          end
        end
        DISCARD: begin
          if (AXI4_S_IP_TX_TLAST) state_d = HDR;
        end
        default: state_d = HDR;
      endcase
    end

    any_err  = seq_err || len_err || data_err;
    frame_ok = done && !any_err && !((state_q == PAY) && frame_err_q);

    if (accept) frame_err_d = (state_q == HDR) ? any_err : (frame_err_q || any_err);

    word_cnt_d     = word_cnt_q + {31'd0, accept};
    frame_cnt_d    = frame_cnt_q + {31'd0, frame_ok};
    seq_err_cnt_d  = sat_inc16(seq_err_cnt_q, seq_err);
    len_err_cnt_d  = sat_inc16(len_err_cnt_q, len_err);
    data_err_cnt_d = sat_inc16(data_err_cnt_q, data_err);
    err_cnt_d      = (any_err && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    err_pulse_d    = any_err;

    if (CLEAR_COUNTS) begin
      state_d        = HDR;
      in_sync_d      = 1'b0;
      frame_err_d    = 1'b0;
      err_pulse_d    = 1'b0;
      word_cnt_d     = '0;
      frame_cnt_d    = '0;
      seq_err_cnt_d  = '0;
      len_err_cnt_d  = '0;
      data_err_cnt_d = '0;
      err_cnt_d      = '0;
    end
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
  always_ff @(posedge USER_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= HDR;
      seq_q          <= '0;
      len_q          <= '0;
      idx_q          <= '0;
      exp_seq_q      <= '0;
      in_sync_q      <= 1'b0;
      frame_err_q    <= 1'b0;
      err_pulse_q    <= 1'b0;
      frame_cnt_q    <= '0;
      word_cnt_q     <= '0;
      seq_err_cnt_q  <= '0;
      len_err_cnt_q  <= '0;
      data_err_cnt_q <= '0;
      err_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      seq_q          <= seq_d;
      len_q          <= len_d;
      idx_q          <= idx_d;
      exp_seq_q      <= exp_seq_d;
      in_sync_q      <= in_sync_d;
      frame_err_q    <= frame_err_d;
      err_pulse_q    <= err_pulse_d;
      frame_cnt_q    <= frame_cnt_d;
      word_cnt_q     <= word_cnt_d;
      seq_err_cnt_q  <= seq_err_cnt_d;
      len_err_cnt_q  <= len_err_cnt_d;
      data_err_cnt_q <= data_err_cnt_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign FRAME_COUNT    = frame_cnt_q;
  assign WORD_COUNT     = word_cnt_q;
  assign SEQ_ERR_COUNT  = seq_err_cnt_q;
  assign LEN_ERR_COUNT  = len_err_cnt_q;
  assign DATA_ERR_COUNT = data_err_cnt_q;
  assign ERR_COUNT      = err_cnt_q;
  assign ERR_PULSE      = err_pulse_q;
  assign IN_SYNC        = in_sync_q;

endmodule

// File: tb/tb_rx_frame_monitor.sv
// Self-checking bench for rx_frame_monitor: per-cycle ERR_PULSE scoreboard plus
// counter checks at the end of each scenario.
module tb_rx_frame_monitor;

  logic        clk;
  logic        reset_n;
  logic        channel_up;
  logic        clear_counts;
  logic [0:31] tdata;
  logic [0:3]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic [0:31] frame_count;
  logic [0:31] word_count;
  logic [0:15] seq_err_count;
  logic [0:15] len_err_count;
  logic [0:15] data_err_count;
  logic [0:7]  err_count;
  logic        err_pulse;
  logic        in_sync;

  rx_frame_monitor #(.MAX_LEN(256)) dut (
    .USER_CLK            (clk),
    .RESET_N             (reset_n),
    .CHANNEL_UP          (channel_up),
    .CLEAR_COUNTS        (clear_counts),
    .AXI4_S_IP_TX_TDATA  (tdata),
    .AXI4_S_IP_TX_TKEEP  (tkeep),
    .AXI4_S_IP_TX_TLAST  (tlast),
    .AXI4_S_IP_TX_TVALID (tvalid),
    .FRAME_COUNT         (frame_count),
    .WORD_COUNT          (word_count),
    .SEQ_ERR_COUNT       (seq_err_count),
    .LEN_ERR_COUNT       (len_err_count),
    .DATA_ERR_COUNT      (data_err_count),
    .ERR_COUNT           (err_count),
    .ERR_PULSE           (err_pulse),
    .IN_SYNC             (in_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic        exp;
  } sb_t;

  sb_t         sb_q[$];
  sb_t         sb_head;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected ERR_PULSE per driven cycle, compared one edge after the beat is captured.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      sb_head = sb_q.pop_front();
      if (sb_head.exp !== 1'bx) begin
        n_checks++;
        if (err_pulse !== sb_head.exp) begin
          n_fail++;
          $display("FAIL err_pulse at cycle %0d: got %b, expected %b", cyc, err_pulse, sb_head.exp);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input logic v, input logic [31:0] d, input logic [3:0] k, input logic l,
                      input logic cu, input logic clr, input logic exp);
    sb_t e;
    @(posedge clk);
    #1;
    tvalid = v; tdata = d; tkeep = k; tlast = l; channel_up = cu; clear_counts = clr;
    e.due = cyc + 1;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic settle();
    idle();
    @(negedge clk);
  endtask

  // Header plus n_pay payload beats; err_beat is the beat index (0 = header) expected to pulse.
  task automatic send_frame(input logic [15:0] s, input logic [15:0] n, input int n_pay,
                            input int bad_idx, input int err_beat, input int keep_beat,
                            input bit gaps, input bit close);
    logic [31:0] d;
    for (int b = 0; b <= n_pay; b++) begin
      if (b == 0)                d = {s, n};
      else if (b - 1 == bad_idx) d = 32'hDEADBEEF;
      else                       d = {s, 16'(b - 1)};
      step(1'b1, d, (b == keep_beat) ? 4'h7 : 4'hF, close && (b == n_pay), 1'b1, 1'b0, b == err_beat);
      if (gaps && b != n_pay) idle();
    end
  endtask

  task automatic good_frame(input logic [15:0] s, input logic [15:0] n);
    send_frame(s, n, int'(n), -1, -1, -1, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tvalid = 1'b0; tdata = '0; tkeep = 4'hF; tlast = 1'b0; channel_up = 1'b1; clear_counts = 1'b0;
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tvalid = 1'b0; tdata = '0; tkeep = 4'hF; tlast = 1'b0; channel_up = 1'b1; clear_counts = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (frame_count !== 32'd0) begin n_fail++; $display("FAIL reset.frame_count: got %0d, expected 0", frame_count); end
    n_checks++; if (word_count !== 32'd0) begin n_fail++; $display("FAIL reset.word_count: got %0d, expected 0", word_count); end
    n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset.err_pulse: got %b, expected 0", err_pulse); end
    do_reset();
    @(negedge clk);
    n_checks++; if (seq_err_count !== 16'd0) begin n_fail++; $display("FAIL reset.seq_err: got %0d, expected 0", seq_err_count); end
    n_checks++; if (len_err_count !== 16'd0) begin n_fail++; $display("FAIL reset.len_err: got %0d, expected 0", len_err_count); end
    n_checks++; if (data_err_count !== 16'd0) begin n_fail++; $display("FAIL reset.data_err: got %0d, expected 0", data_err_count); end
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset.err_count: got %0d, expected 0", err_count); end
    n_checks++; if (in_sync !== 1'b0) begin n_fail++; $display("FAIL reset.in_sync: got %b, expected 0", in_sync); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 10; i++) good_frame(16'(i), 16'd4);
    settle();
    n_checks++; if (frame_count !== 32'd10) begin n_fail++; $display("FAIL b2b.frame_count: got %0d, expected 10", frame_count); end
    n_checks++; if (word_count !== 32'd50) begin n_fail++; $display("FAIL b2b.word_count: got %0d, expected 50", word_count); end
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL b2b.err_count: got %0d, expected 0", err_count); end
    n_checks++; if (seq_err_count !== 16'd0 || len_err_count !== 16'd0 || data_err_count !== 16'd0) begin n_fail++; $display("FAIL b2b.type_counts: got seq %0d len %0d data %0d, expected all 0", seq_err_count, len_err_count, data_err_count); end
    n_checks++; if (in_sync !== 1'b1) begin n_fail++; $display("FAIL b2b.in_sync: got %b, expected 1", in_sync); end
  endtask

  task automatic test_sequence();
    do_reset();
    good_frame(16'd5, 16'd2);
    good_frame(16'd6, 16'd2);
    send_frame(16'd8, 16'd2, 2, -1, 0, -1, 1'b0, 1'b1);
    good_frame(16'd9, 16'd2);
    settle();
    n_checks++; if (seq_err_count !== 16'd1) begin n_fail++; $display("FAIL seq.seq_err: got %0d, expected 1", seq_err_count); end
    n_checks++; if (frame_count !== 32'd3) begin n_fail++; $display("FAIL seq.frame_count: got %0d, expected 3", frame_count); end
    n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL seq.err_count: got %0d, expected 1", err_count); end
  endtask

  task automatic test_data_error();
    do_reset();
    send_frame(16'd0, 16'd4, 4, 2, 3, -1, 1'b0, 1'b1);
    settle();
    n_checks++; if (data_err_count !== 16'd1) begin n_fail++; $display("FAIL data.data_err: got %0d, expected 1", data_err_count); end
    n_checks++; if (frame_count !== 32'd0) begin n_fail++; $display("FAIL data.frame_count: got %0d, expected 0", frame_count); end
    n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL data.err_count: got %0d, expected 1", err_count); end
  endtask

  task automatic test_length();
    do_reset();
    send_frame(16'd0, 16'd4, 2, -1, 2, -1, 1'b0, 1'b1);
    good_frame(16'd1, 16'd2);
    settle();
    n_checks++; if (len_err_count !== 16'd1) begin n_fail++; $display("FAIL len_early.len_err: got %0d, expected 1", len_err_count); end
    n_checks++; if (frame_count !== 32'd1) begin n_fail++; $display("FAIL len_early.frame_count: got %0d, expected 1", frame_count); end
    do_reset();
    send_frame(16'd0, 16'd300, 3, -1, 0, -1, 1'b0, 1'b1);
    good_frame(16'd1, 16'd2);
    settle();
    n_checks++; if (len_err_count !== 16'd1) begin n_fail++; $display("FAIL len_long.len_err: got %0d, expected 1", len_err_count); end
    n_checks++; if (frame_count !== 32'd1) begin n_fail++; $display("FAIL len_long.frame_count: got %0d, expected 1", frame_count); end
    n_checks++; if (word_count !== 32'd7) begin n_fail++; $display("FAIL len_long.word_count: got %0d, expected 7", word_count); end
  endtask

  task automatic test_boundary();
    do_reset();
    good_frame(16'd7, 16'd0);
    good_frame(16'd8, 16'd256);
    send_frame(16'd9, 16'd257, 2, -1, 0, -1, 1'b0, 1'b1);
    send_frame(16'd10, 16'd2, 2, -1, 1, 1, 1'b0, 1'b1);
    send_frame(16'd11, 16'd3, 3, -1, -1, -1, 1'b1, 1'b1);
    send_frame(16'd12, 16'd0, 1, -1, 0, -1, 1'b0, 1'b1);
    good_frame(16'd13, 16'd1);
    settle();
    n_checks++; if (frame_count !== 32'd4) begin n_fail++; $display("FAIL bound.frame_count: got %0d, expected 4", frame_count); end
    n_checks++; if (len_err_count !== 16'd3) begin n_fail++; $display("FAIL bound.len_err: got %0d, expected 3", len_err_count); end
    n_checks++; if (word_count !== 32'd272) begin n_fail++; $display("FAIL bound.word_count: got %0d, expected 272", word_count); end
    n_checks++; if (seq_err_count !== 16'd0 || data_err_count !== 16'd0) begin n_fail++; $display("FAIL bound.seq_data: got seq %0d data %0d, expected 0 0", seq_err_count, data_err_count); end
    n_checks++; if (err_count !== 8'd3) begin n_fail++; $display("FAIL bound.err_count: got %0d, expected 3", err_count); end
  endtask

  task automatic test_channel_drop();
    do_reset();
    send_frame(16'd0, 16'd8, 3, -1, -1, -1, 1'b0, 1'b0);
    step(1'b1, 32'hCAFE0000, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hCAFE0001, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (in_sync !== 1'b0) begin n_fail++; $display("FAIL chan.in_sync_low: got %b, expected 0", in_sync); end
    n_checks++; if (word_count !== 32'd4) begin n_fail++; $display("FAIL chan.word_ignored: got %0d, expected 4", word_count); end
    good_frame(16'd100, 16'd2);
    settle();
    n_checks++; if (len_err_count !== 16'd1) begin n_fail++; $display("FAIL chan.len_err: got %0d, expected 1", len_err_count); end
    n_checks++; if (seq_err_count !== 16'd0) begin n_fail++; $display("FAIL chan.seq_err: got %0d, expected 0", seq_err_count); end
    n_checks++; if (frame_count !== 32'd1) begin n_fail++; $display("FAIL chan.frame_count: got %0d, expected 1", frame_count); end
    n_checks++; if (in_sync !== 1'b1) begin n_fail++; $display("FAIL chan.in_sync: got %b, expected 1", in_sync); end
  endtask

  task automatic test_saturation_clear();
    do_reset();
    for (int i = 0; i < 300; i++) send_frame(16'(i), 16'd1, 1, 0, 1, -1, 1'b0, 1'b1);
    settle();
    n_checks++; if (data_err_count !== 16'd300) begin n_fail++; $display("FAIL sat.data_err: got %0d, expected 300", data_err_count); end
    n_checks++; if (err_count !== 8'hFF) begin n_fail++; $display("FAIL sat.err_count: got %0d, expected 255", err_count); end
    n_checks++; if (word_count !== 32'd600) begin n_fail++; $display("FAIL sat.word_count: got %0d, expected 600", word_count); end
    step(1'b1, {16'd0, 16'd1}, 4'hF, 1'b0, 1'b1, 1'b1, 1'bx);
    settle();
    n_checks++; if (frame_count !== 32'd0 || word_count !== 32'd0) begin n_fail++; $display("FAIL clear.frame_word: got %0d %0d, expected 0 0", frame_count, word_count); end
    n_checks++; if (seq_err_count !== 16'd0 || len_err_count !== 16'd0 || data_err_count !== 16'd0) begin n_fail++; $display("FAIL clear.type_counts: got seq %0d len %0d data %0d, expected all 0", seq_err_count, len_err_count, data_err_count); end
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL clear.err_count: got %0d, expected 0", err_count); end
    n_checks++; if (in_sync !== 1'b0) begin n_fail++; $display("FAIL clear.in_sync: got %b, expected 0", in_sync); end
    good_frame(16'd5, 16'd1);
    settle();
    n_checks++; if (frame_count !== 32'd1) begin n_fail++; $display("FAIL clear.hdr_after: got %0d, expected 1", frame_count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    good_frame(16'd0, 16'd2);
    good_frame(16'd1, 16'd2);
    settle();
    n_checks++; if (frame_count !== 32'd2) begin n_fail++; $display("FAIL areset.pre_frames: got %0d, expected 2", frame_count); end
    step(1'b1, {16'd2, 16'd4}, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    sb_q.delete();
    #1;
    n_checks++; if (frame_count !== 32'd0 || word_count !== 32'd0) begin n_fail++; $display("FAIL areset.counts: got %0d %0d, expected 0 0", frame_count, word_count); end
    n_checks++; if (in_sync !== 1'b0) begin n_fail++; $display("FAIL areset.in_sync: got %b, expected 0", in_sync); end
    do_reset();
    good_frame(16'd50, 16'd1);
    settle();
    n_checks++; if (frame_count !== 32'd1 || word_count !== 32'd2) begin n_fail++; $display("FAIL areset.after: got frames %0d words %0d, expected 1 2", frame_count, word_count); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_sequence();
    test_data_error();
    test_length();
    test_boundary();
    test_channel_drop();
    test_saturation_clear();
    test_async_reset();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_frame_monitor.md
# rx_frame_monitor

Receive-side frame monitor on the Aurora user-clock domain. It consumes the Aurora RX AXI4-Stream (no back-pressure) from the lane and checks every frame against the team's sequenced test-frame format: header, sequence number, length and payload pattern. It keeps frame, word and error statistics for the status registers, and sits directly downstream of the Aurora core RX interface, in parallel with the frame checker and loopback paths.

## Interface
- MAX_LEN, 256: largest legal payload length in words (1..65535).
- USER_CLK, input, 1: Aurora user clock; all logic is on its rising edge.
- RESET_N, input, 1: asynchronous, active-low reset.
- CHANNEL_UP, input, 1: Aurora channel status. Beats are ignored while it is low.
- CLEAR_COUNTS, input, 1: synchronous clear of all counters and of sequence sync.
- AXI4_S_IP_TX_TDATA, input, [0:31]: RX data.
- AXI4_S_IP_TX_TKEEP, input, [0:3]: RX byte enables.
- AXI4_S_IP_TX_TLAST, input, 1: RX end of frame.
- AXI4_S_IP_TX_TVALID, input, 1: RX beat valid. There is no TREADY; the block accepts every beat.
- FRAME_COUNT, output, [0:31]: good frames received. Wraps.
- WORD_COUNT, output, [0:31]: valid beats received. Wraps.
- SEQ_ERR_COUNT, output, [0:15]: sequence errors. Saturates at 16'hFFFF.
- LEN_ERR_COUNT, output, [0:15]: length, framing and TKEEP errors. Saturates.
- DATA_ERR_COUNT, output, [0:15]: payload mismatches. Saturates.
- ERR_COUNT, output, [0:7]: total errors of all kinds. Saturates at 8'hFF.
- ERR_PULSE, output, 1: one-cycle pulse on any error.
- IN_SYNC, output, 1: the expected sequence number is valid.

## Operation
- Frame format:
  - Header beat: [0:15] is the sequence number S; [16:31] is the payload length N.
  - N payload beats follow. Payload k (k = 0..N-1) is {S, k[15:0]}.
  - TLAST is set on the last beat: the header when N = 0, otherwise payload N-1.
  - Every beat must have TKEEP = 4'hF.
- A beat is accepted when TVALID and CHANNEL_UP are both high. WORD_COUNT increments on every accepted beat.
- FSM states: HDR, PAY, DISCARD.
- In HDR, on an accepted beat, latch S and N and clear the payload index k.
  - N > MAX_LEN: length error. Go to DISCARD if TLAST = 0, otherwise stay in HDR.
  - N = 0 and TLAST = 1: frame complete, stay in HDR.
  - N = 0 and TLAST = 0: length error, go to DISCARD.
  - N > 0 and TLAST = 1: length error (truncated), stay in HDR.
  - Otherwise go to PAY.
- Sequence check on every header:
  - IN_SYNC = 0: no check; set expected = S+1 (mod 2^16) and set IN_SYNC.
  - IN_SYNC = 1 and S ≠ expected: sequence error; resync expected = S+1.
  - Match: expected = S+1.
- In PAY, on each accepted beat, compare the data with {S, k}. A mismatch is one data error; k then increments.
  - TLAST before beat N-1: length error, go to HDR.
  - Beat N-1 without TLAST: length error, go to DISCARD.
  - Beat N-1 with TLAST: frame complete, go to HDR.
- DISCARD: drop beats until an accepted TLAST, then go to HDR. No data checks are made.
- FRAME_COUNT increments once per completed frame with zero errors of any kind within that frame.
- TKEEP ≠ 4'hF on an accepted beat is a length error, at most one per beat. The other checks on that beat still run.
- Error accounting:
  - Several error types on one beat increment every applicable type counter.
  - ERR_COUNT increments by 1 per beat, regardless of how many types fired.
  - ERR_PULSE is asserted for that beat.
- CHANNEL_UP falling:
  - In PAY: one length error (truncation), then go to HDR.
  - In DISCARD: go to HDR with no error.
  - IN_SYNC clears in every state. Counters hold.
- CLEAR_COUNTS has priority over increments in the same cycle. It zeroes all counters, clears IN_SYNC and forces HDR.

## Timing
- Reset values: all counters 0, ERR_PULSE 0, IN_SYNC 0, FSM in HDR, expected sequence 0.
- Counters, ERR_PULSE and IN_SYNC are registered. They reflect an accepted beat on the next USER_CLK edge (latency 1).
- Back-to-back frames are supported with zero idle cycles: a header may directly follow a TLAST beat.
- Beats with TVALID low cause no state change; gaps inside a frame are legal.
- Counter arithmetic:
  - 32-bit counters wrap from 32'hFFFFFFFF to 0.
  - 16-bit and 8-bit counters hold at all-ones.
- Payload index k is 16 bits. N ≤ MAX_LEN ≤ 65535, so k never wraps inside a frame.
- Asserting RESET_N low mid-frame returns every output to its reset value immediately (asynchronously). Reset release is synchronised internally.

## Test plan
- Ten good frames, S = 0..9, N = 4, back-to-back: FRAME_COUNT = 10, WORD_COUNT = 50, all error counters 0, IN_SYNC = 1.
- Frames S = 5, 6, 8, 9: one sequence error, FRAME_COUNT = 3, ERR_COUNT = 1.
- Frame S = 0, N = 4 with payload 2 corrupted to 32'hDEADBEEF: DATA_ERR_COUNT = 1, FRAME_COUNT = 0, ERR_PULSE high for exactly one cycle, one cycle after the bad beat.
- Length cases:
  - N = 4 but TLAST on payload 1: LEN_ERR_COUNT = 1, FSM back in HDR.
  - N = 300 with MAX_LEN = 256: LEN_ERR = 1, beats discarded until TLAST.
  - A following good frame still counts, FRAME_COUNT = 1.
- CHANNEL_UP dropped in the middle of the payload, then restored and a frame with arbitrary S sent: LEN_ERR_COUNT = 1, SEQ_ERR_COUNT = 0 (resync), FRAME_COUNT = 1.
- 300 corrupted frames: DATA_ERR_COUNT = 300 and ERR_COUNT saturated at 8'hFF. Then CLEAR_COUNTS asserted in the same cycle as an erroring beat: all counters 0 and IN_SYNC 0 on the next cycle.
